id_stage: RTL and testbench

Instruction decode stage of the 5-stage 8-bit pipeline. It accepts assembled instructions (opcode, operand, immediate) from the instruction fetch stage and decodes them into control signals. It reads the source register, detects RAW hazards with a 3-entry in-flight scoreboard, and back-pressures fetch with `stall`. Decoded instructions are issued into the ID/EX pipeline register, and the block raises a sticky `halt` when HLT issues.

---
 rtl/id_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: instruction decode stage of the 5-stage 8-bit pipeline.
//
// Takes {opcode, ad1, imm} from fetch and buffers it in a 2-entry skid FIFO.
// The FIFO is bypassed when it is empty. The head instruction is decoded and
// its register-file read address is driven. RAW hazards are detected against
// a 3-slot scoreboard of in-flight destinations (EX, MEM, WB). A hazard-free
// head is issued into the ID/EX register. HLT sets a sticky halt, flushes the
// FIFO and blocks all further issue until reset.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_opcode/ad1/imm   instruction from fetch, qualified by in_valid
//   stall               to fetch: hold PC (depends on registered state only)
//   halt                sticky halt, set on the HLT issue edge
//   rf_raddr, rf_rdata  combinational register file read port
//   ex_*                ID/EX pipeline register: valid, fields, source value,
//                       and controls we_reg/we_acc/rom_rd/mem_rd/mem_wr
//   issue_cnt           (ID_STAGE_STATS_EN only) saturating count of issue edges
//   bubble_cnt          (ID_STAGE_STATS_EN only) saturating count of edges
//                       where the head was blocked by a hazard
//
// Build option: define ID_STAGE_STATS_EN to add the statistics counters.
module id_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_opcode,
  input  logic [4:0] in_ad1,
  input  logic [7:0] in_imm,
  input  logic       in_valid,
  output logic       stall,
  output logic       halt,
  output logic [4:0] rf_raddr,
  input  logic [7:0] rf_rdata,
  output logic       ex_valid,
  output logic [2:0] ex_opcode,
  output logic [4:0] ex_ad1,
  output logic [7:0] ex_imm,
  output logic [7:0] ex_rdata,
  output logic       ex_we_reg,
  output logic       ex_we_acc,
  output logic       ex_rom_rd,
  output logic       ex_mem_rd,
  output logic       ex_mem_wr
`ifdef ID_STAGE_STATS_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_LDO = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STO = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_LDM = 3'b110;

  // Register tags are 0..31; the accumulator is tag 32.
  localparam logic [5:0] TAG_ACC = 6'd32;

  typedef struct packed {
    logic       src_a_v;   // reads R[ad1]
    logic       src_b_v;   // reads ACC
    logic       dst_v;
    logic [5:0] dst_tag;
    logic       we_reg;
    logic       we_acc;
    logic       rom_rd;
    logic       mem_rd;
    logic       mem_wr;
  } dec_t;

  function automatic dec_t decode(input logic [2:0] op, input logic [4:0] ad1);
    dec_t d;
    d = '0;
    case (op)
      OP_LDO: begin
        d.dst_v = 1'b1; d.dst_tag = {1'b0, ad1}; d.we_reg = 1'b1; d.rom_rd = 1'b1;
      end
      OP_LDA: begin
        d.dst_v = 1'b1; d.dst_tag = {1'b0, ad1}; d.we_reg = 1'b1; d.mem_rd = 1'b1;
      end
      OP_STO: begin
        d.src_a_v = 1'b1; d.mem_wr = 1'b1;
      end
      OP_PRE: begin
        d.src_a_v = 1'b1; d.dst_v = 1'b1; d.dst_tag = TAG_ACC; d.we_acc = 1'b1;
      end
      OP_ADD: begin
        d.src_a_v = 1'b1; d.src_b_v = 1'b1;
        d.dst_v = 1'b1; d.dst_tag = TAG_ACC; d.we_acc = 1'b1;
      end
      OP_LDM: begin
        d.src_b_v = 1'b1; d.dst_v = 1'b1; d.dst_tag = {1'b0, ad1}; d.we_reg = 1'b1;
      end
      default: ;  // HLT and NOP: no sources, no destination, no controls
    endcase
    return d;
  endfunction

  function automatic logic slot_hit(input logic vld, input logic [5:0] tag,
                                    input dec_t d, input logic [4:0] ad1);
    return vld && ((d.src_a_v && (tag == {1'b0, ad1})) ||
                   (d.src_b_v && (tag == TAG_ACC)));
  endfunction

`ifdef ID_STAGE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Skid FIFO: entry 0 is always the head; entries shift down on pop.
  logic [1:0] fifo_cnt;
  logic [2:0] fifo_op  [2];
  logic [4:0] fifo_ad1 [2];
  logic [7:0] fifo_imm [2];

  // Scoreboard slots: p0 = EX, p1 = MEM, p2 = WB.
  logic       sb_vld_p0, sb_vld_p1, sb_vld_p2;
  logic [5:0] sb_tag_p0, sb_tag_p1, sb_tag_p2;

  logic       fifo_ne;
  logic       head_vld;
  logic [2:0] head_op;
  logic [4:0] head_ad1;
  logic [7:0] head_imm;
  dec_t       hd;
  logic       blocked;
  logic       issue;
  logic       halt_set;
  logic       pop;
  logic       push;
  logic       wr_sel;

  always_comb begin
    fifo_ne  = (fifo_cnt != 2'd0);
    head_vld = fifo_ne | in_valid;
    head_op  = fifo_ne ? fifo_op[0]  : in_opcode;
    head_ad1 = fifo_ne ? fifo_ad1[0] : in_ad1;
    head_imm = fifo_ne ? fifo_imm[0] : in_imm;
    hd       = decode(head_op, head_ad1);

    blocked  = slot_hit(sb_vld_p0, sb_tag_p0, hd, head_ad1) |
               slot_hit(sb_vld_p1, sb_tag_p1, hd, head_ad1) |
               slot_hit(sb_vld_p2, sb_tag_p2, hd, head_ad1);

    issue    = head_vld & ~blocked & ~halt;
    halt_set = issue & (head_op == OP_HLT);
    pop      = issue & fifo_ne;
    // A live input is dropped once halted or on the HLT issue edge; otherwise
    // it is stored unless it was the instruction that bypassed the FIFO.
    push     = in_valid & ~halt & ~halt_set & ~(issue & ~fifo_ne);
    // Slot the pushed entry lands in after any simultaneous pop.
    wr_sel   = (fifo_cnt == 2'd2) | ((fifo_cnt == 2'd1) & ~pop);

    rf_raddr = head_ad1;
    // With one entry buffered the head is that entry, so blocked here depends
    // only on registered state.
    stall    = halt | (fifo_cnt == 2'd2) | ((fifo_cnt == 2'd1) & blocked);
  end

  // ---- ID control state and ID/EX register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt  <= 2'd0;
      halt      <= 1'b0;
      sb_vld_p0 <= 1'b0;
      sb_vld_p1 <= 1'b0;
      sb_vld_p2 <= 1'b0;
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_ad1    <= '0;
      ex_imm    <= '0;
      ex_rdata  <= '0;
      ex_we_reg <= 1'b0;
      ex_we_acc <= 1'b0;
      ex_rom_rd <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
    end else begin
      fifo_cnt  <= halt_set ? 2'd0 : fifo_cnt + {1'b0, push} - {1'b0, pop};
      halt      <= halt | halt_set;
      sb_vld_p0 <= issue & hd.dst_v;
      sb_vld_p1 <= sb_vld_p0;
      sb_vld_p2 <= sb_vld_p1;
      ex_valid  <= issue;
      ex_we_reg <= issue & hd.we_reg;
      ex_we_acc <= issue & hd.we_acc;
      ex_rom_rd <= issue & hd.rom_rd;
      ex_mem_rd <= issue & hd.mem_rd;
      ex_mem_wr <= issue & hd.mem_wr;
      if (issue) begin
        ex_opcode <= head_op;
        ex_ad1    <= head_ad1;
        ex_imm    <= head_imm;
        ex_rdata  <= rf_rdata;
      end
    end
  end

  // ---- FIFO storage and scoreboard tags (data, not reset) ----
  always_ff @(posedge clk) begin
    if (pop) begin
      fifo_op[0]  <= fifo_op[1];
      fifo_ad1[0] <= fifo_ad1[1];
      fifo_imm[0] <= fifo_imm[1];
    end
    if (push) begin
      fifo_op[wr_sel]  <= in_opcode;
      fifo_ad1[wr_sel] <= in_ad1;
      fifo_imm[wr_sel] <= in_imm;
    end
    sb_tag_p0 <= hd.dst_tag;
    sb_tag_p1 <= sb_tag_p0;
    sb_tag_p2 <= sb_tag_p1;
  end

`ifdef ID_STAGE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (issue)              issue_cnt  <= sat_inc(issue_cnt);
      if (head_vld & blocked) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] LDO = 3'b001;
  localparam logic [2:0] LDA = 3'b010;
  localparam logic [2:0] STO = 3'b011;
  localparam logic [2:0] PRE = 3'b100;
  localparam logic [2:0] ADD = 3'b101;
  localparam logic [2:0] LDM = 3'b110;
  localparam logic [2:0] NOP = 3'b111;

  // ctrl vector order: {we_reg, we_acc, rom_rd, mem_rd, mem_wr}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LDO  = 5'b10100;
  localparam logic [4:0] C_LDA  = 5'b10010;
  localparam logic [4:0] C_STO  = 5'b00001;
  localparam logic [4:0] C_ACC  = 5'b01000;
  localparam logic [4:0] C_LDM  = 5'b10000;

  logic       clk;
  logic       rst;
  logic [2:0] in_opcode;
  logic [4:0] in_ad1;
  logic [7:0] in_imm;
  logic       in_valid;
  logic       stall;
  logic       halt;
  logic [4:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       ex_valid;
  logic [2:0] ex_opcode;
  logic [4:0] ex_ad1;
  logic [7:0] ex_imm;
  logic [7:0] ex_rdata;
  logic       ex_we_reg, ex_we_acc, ex_rom_rd, ex_mem_rd, ex_mem_wr;
  logic [4:0] ex_ctrl;
`ifdef ID_STAGE_STATS_EN
  logic [15:0] issue_cnt, bubble_cnt;
  logic [15:0] ic0, bc0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Register file model: R[n] holds 0x40 + n.
  assign rf_rdata = 8'h40 | {3'b000, rf_raddr};
  assign ex_ctrl  = {ex_we_reg, ex_we_acc, ex_rom_rd, ex_mem_rd, ex_mem_wr};

  id_stage dut (
    .clk(clk), .rst(rst),
    .in_opcode(in_opcode), .in_ad1(in_ad1), .in_imm(in_imm), .in_valid(in_valid),
    .stall(stall), .halt(halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_ad1(ex_ad1),
    .ex_imm(ex_imm), .ex_rdata(ex_rdata),
    .ex_we_reg(ex_we_reg), .ex_we_acc(ex_we_acc), .ex_rom_rd(ex_rom_rd),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr)
`ifdef ID_STAGE_STATS_EN
    , .issue_cnt(issue_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] op, input logic [4:0] ad,
                     input logic [7:0] imm);
    in_valid  = v;
    in_opcode = op;
    in_ad1    = ad;
    in_imm    = imm;
  endtask

  // Advance one clock; a push into a full FIFO must never be attempted.
  task automatic tick();
    chk("fifo_ovf", 16'(dut.push && !dut.pop && (dut.fifo_cnt == 2'd2)), 16'd0);
    @(posedge clk);
    #1;
  endtask

  // One fetch cycle: present inputs, check stall for this cycle, clock.
  task automatic cyc(input string tag, input logic v, input logic [2:0] op,
                     input logic [4:0] ad, input logic [7:0] imm, input logic exp_stall);
    drv(v, op, ad, imm);
    #1;
    chk({tag, ".stall"}, 16'(stall), 16'(exp_stall));
    tick();
  endtask

  task automatic ex_chk(input string tag, input logic v, input logic [2:0] op,
                        input logic [4:0] ad, input logic [7:0] imm,
                        input logic [7:0] rd, input logic [4:0] ctrl);
    chk({tag, ".valid"}, 16'(ex_valid), 16'(v));
    chk({tag, ".ctrl"},  16'(ex_ctrl),  16'(ctrl));
    if (v) begin
      chk({tag, ".op"},    16'(ex_opcode), 16'(op));
      chk({tag, ".ad1"},   16'(ex_ad1),    16'(ad));
      chk({tag, ".imm"},   16'(ex_imm),    16'(imm));
      chk({tag, ".rdata"}, 16'(ex_rdata),  16'(rd));
    end
  endtask

  task automatic bub(input string tag);
    ex_chk(tag, 1'b0, 3'd0, 5'd0, 8'd0, 8'd0, C_NONE);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, NOP, 5'd0, 8'd0);
    #1;
    // Reset state
    chk("rst.stall", 16'(stall), 16'd0);
    chk("rst.halt",  16'(halt),  16'd0);
    ex_chk("rst", 1'b0, 3'd0, 5'd0, 8'd0, 8'd0, C_NONE);
    chk("rst.op",    16'(ex_opcode), 16'd0);
    chk("rst.rdata", 16'(ex_rdata),  16'd0);
`ifdef ID_STAGE_STATS_EN
    chk("rst.issue_cnt",  issue_cnt,  16'd0);
    chk("rst.bubble_cnt", bubble_cnt, 16'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back independent instructions, one-cycle bypass latency
    drv(1'b1, LDO, 5'd1, 8'd10);
    #1;
    chk("b2b.raddr", 16'(rf_raddr), 16'd1);
    cyc("b2b0", 1'b1, LDO, 5'd1, 8'd10, 1'b0);
    ex_chk("b2b_ldo", 1'b1, LDO, 5'd1, 8'd10, 8'h41, C_LDO);
    cyc("b2b1", 1'b1, LDA, 5'd2, 8'd20, 1'b0);
    ex_chk("b2b_lda", 1'b1, LDA, 5'd2, 8'd20, 8'h42, C_LDA);
    cyc("b2b2", 1'b1, NOP, 5'd0, 8'd0, 1'b0);
    ex_chk("b2b_nop", 1'b1, NOP, 5'd0, 8'd0, 8'h40, C_NONE);
    cyc("b2b3", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
    bub("b2b_end");
    idle(3);

    // Load-use: LDA R3 then STO R3 (3 bubbles), then NOP fills the FIFO
`ifdef ID_STAGE_STATS_EN
    ic0 = issue_cnt;
    bc0 = bubble_cnt;
`endif
    cyc("lu0", 1'b1, LDA, 5'd3, 8'd5, 1'b0);
    ex_chk("lu_lda", 1'b1, LDA, 5'd3, 8'd5, 8'h43, C_LDA);
    cyc("lu1", 1'b1, STO, 5'd3, 8'd6, 1'b0);
    bub("lu_b1");
    cyc("lu2", 1'b1, NOP, 5'd0, 8'd0, 1'b1);
    bub("lu_b2");
    cyc("lu3", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
    bub("lu_b3");
    cyc("lu4", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
    ex_chk("lu_sto", 1'b1, STO, 5'd3, 8'd6, 8'h43, C_STO);
`ifdef ID_STAGE_STATS_EN
    chk("lu.issue_cnt",  issue_cnt - ic0,  16'd2);
    chk("lu.bubble_cnt", bubble_cnt - bc0, 16'd3);
`endif
    cyc("lu5", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
    ex_chk("lu_nop", 1'b1, NOP, 5'd0, 8'd0, 8'h40, C_NONE);
    cyc("lu6", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
    bub("lu_end");
    idle(2);

    // Producer two instructions ahead: 2 bubbles
    cyc("d2_0", 1'b1, LDO, 5'd1, 8'd1, 1'b0);
    ex_chk("d2_ldo", 1'b1, LDO, 5'd1, 8'd1, 8'h41, C_LDO);
    cyc("d2_1", 1'b1, NOP, 5'd0, 8'd0, 1'b0);
    ex_chk("d2_nop", 1'b1, NOP, 5'd0, 8'd0, 8'h40, C_NONE);
    cyc("d2_2", 1'b1, STO, 5'd1, 8'd2, 1'b0);
    bub("d2_b1");
    cyc("d2_3", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
    bub("d2_b2");
    cyc("d2_4", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
    ex_chk("d2_sto", 1'b1, STO, 5'd1, 8'd2, 8'h41, C_STO);
    cyc("d2_5", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
    bub("d2_end");
    idle(2);

    // ACC chain: PRE R1; ADD R2; LDM R4
    cyc("acc0", 1'b1, PRE, 5'd1, 8'd0, 1'b0);
    ex_chk("acc_pre", 1'b1, PRE, 5'd1, 8'd0, 8'h41, C_ACC);
    cyc("acc1", 1'b1, ADD, 5'd2, 8'd0, 1'b0);
    bub("acc_b1");
    cyc("acc2", 1'b1, LDM, 5'd4, 8'd0, 1'b1);
    bub("acc_b2");
    cyc("acc3", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
    bub("acc_b3");
    cyc("acc4", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
    ex_chk("acc_add", 1'b1, ADD, 5'd2, 8'd0, 8'h42, C_ACC);
    cyc("acc5", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
    bub("acc_b4");
    cyc("acc6", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
    bub("acc_b5");
    cyc("acc7", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
    bub("acc_b6");
    cyc("acc8", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
    ex_chk("acc_ldm", 1'b1, LDM, 5'd4, 8'd0, 8'h44, C_LDM);
    idle(4);

    // Reset mid-stream with two buffered instructions
    cyc("mr0", 1'b1, LDA, 5'd3, 8'd5, 1'b0);
    ex_chk("mr_lda", 1'b1, LDA, 5'd3, 8'd5, 8'h43, C_LDA);
    cyc("mr1", 1'b1, STO, 5'd3, 8'd6, 1'b0);
    cyc("mr2", 1'b1, NOP, 5'd0, 8'd0, 1'b1);
    drv(1'b0, NOP, 5'd0, 8'd0);
    #1;
    chk("mr.stall_before", 16'(stall), 16'd1);
    rst = 1'b1;
    #1;
    chk("mr.stall", 16'(stall), 16'd0);
    chk("mr.halt",  16'(halt),  16'd0);
    ex_chk("mr_async", 1'b0, 3'd0, 5'd0, 8'd0, 8'd0, C_NONE);
    chk("mr.op",    16'(ex_opcode), 16'd0);
    chk("mr.ad1",   16'(ex_ad1),    16'd0);
    chk("mr.imm",   16'(ex_imm),    16'd0);
    chk("mr.rdata", 16'(ex_rdata),  16'd0);
    tick();
    rst = 1'b0;
    cyc("mr3", 1'b1, LDO, 5'd5, 8'd7, 1'b0);
    ex_chk("mr_ldo", 1'b1, LDO, 5'd5, 8'd7, 8'h45, C_LDO);
    cyc("mr4", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
    bub("mr_b1");
    cyc("mr5", 1'b0, NOP, 5'd0, 8'd0, 1'b0);
    bub("mr_b2");
    idle(4);

    // Halt: HLT then LDO R1,#1 which must never issue
    chk("h.halt_pre", 16'(halt), 16'd0);
    cyc("h0", 1'b1, HLT, 5'd0, 8'd0, 1'b0);
    ex_chk("h_hlt", 1'b1, HLT, 5'd0, 8'd0, 8'h40, C_NONE);
    chk("h.halt", 16'(halt), 16'd1);
    cyc("h1", 1'b1, LDO, 5'd1, 8'd1, 1'b1);
    bub("h_b1");
    for (int i = 0; i < 3; i++) begin
      cyc("hN", 1'b0, NOP, 5'd0, 8'd0, 1'b1);
      bub("h_bN");
      chk("h.halt_sticky", 16'(halt), 16'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
